// File: rtl/burst_reader_pkg.sv
// burst_reader_pkg: shared types for the burst reader slice.
// Holds the controller state encoding used by burst_reader.
package burst_reader_pkg;

  // Controller states: waiting for a request, reading one word, presenting one beat.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/burst_reader_if.sv
// burst_reader_if: write port, burst request and valid/ready read stream
// of burst_reader bundled together. The slave modport is the reader side,
// the master modport is the producer/consumer side.
interface burst_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) ();

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH:0]   burst_len;
  logic                  busy;

  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;
  logic                  done;
  logic                  err;

  modport master (
    output wr_en, wr_addr, wr_data,
    output start, start_addr, burst_len,
    output rd_ready,
    input  busy, rd_valid, rd_data, rd_last, done, err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  start, start_addr, burst_len,
    input  rd_ready,
    output busy, rd_valid, rd_data, rd_last, done, err
  );

endinterface

// File: rtl/burst_reader_mem.sv
// burst_reader_mem: simple dual-port RAM, one write port and one
// synchronous read port. Array contents are never reset; only the read
// output register is cleared so the stream data is defined after reset.
// A read and write to the same address in one cycle returns the old word.
module burst_reader_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port: always accepted, storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: registered output, updated only when a read is issued so it
  // stays stable while the beat is waiting for the consumer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/burst_reader.sv
// burst_reader: drains a burst of consecutive words from an internal buffer
// onto a valid/ready stream. The buffer is filled through a plain write port
// that stays usable during a burst.
// Optional feature macro: BURST_READER_NOWRAP_EN -- when defined, requests
// that would run past the last address are rejected with an err pulse;
// otherwise such bursts wrap through address 0 and err is tied low.
module burst_reader
  import burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  burst_reader_if.slave  bus
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  rd_valid_q;
  logic                  rd_last_q;
  logic                  done_q;
  logic                  req_ok;
  logic                  last_beat;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_word;

  assign last_beat = (remaining == (ADDR_WIDTH+1)'(1));
  assign rd_en     = (state == FETCH);

`ifdef BURST_READER_NOWRAP_EN
  localparam int                  DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH+1:0] DEPTH_EXT = (ADDR_WIDTH+2)'(DEPTH);

  logic [ADDR_WIDTH+1:0] req_end;
  logic                  err_q;

  // One bit of headroom beyond burst_len so start_addr + DEPTH cannot overflow.
  assign req_end  = {2'b00, bus.start_addr} + {1'b0, bus.burst_len};
  assign req_ok   = (req_end <= DEPTH_EXT);
  assign bus.err  = err_q;
`else
  assign req_ok   = 1'b1;
  assign bus.err  = 1'b0;
`endif

  burst_reader_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_en   (rd_en),
    .rd_addr (addr),
    .rd_data (rd_word)
  );

  // Burst controller: accept a request, then alternate read / present until
  // the last beat is handed over.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      addr       <= '0;
      remaining  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      done_q     <= 1'b0;
`ifdef BURST_READER_NOWRAP_EN
      err_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef BURST_READER_NOWRAP_EN
      err_q  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // A zero-length request is dropped without any visible effect.
          if (bus.start && (bus.burst_len != '0)) begin
            if (req_ok) begin
              addr      <= bus.start_addr;
              remaining <= bus.burst_len;
              state     <= FETCH;
            end
`ifdef BURST_READER_NOWRAP_EN
            else begin
              err_q <= 1'b1;
            end
`endif
          end
        end
        FETCH: begin
          // The RAM read issued this cycle lands in rd_word at this edge.
          rd_valid_q <= 1'b1;
          rd_last_q  <= last_beat;
          state      <= HOLD;
        end
        HOLD: begin
          if (rd_valid_q && bus.rd_ready) begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            if (last_beat) begin
              done_q <= 1'b1;
              state  <= IDLE;
            end else begin
              addr      <= addr + ADDR_WIDTH'(1);
              remaining <= remaining - (ADDR_WIDTH+1)'(1);
              state     <= FETCH;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_last  = rd_last_q;
  assign bus.rd_data  = rd_word;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_burst_reader.sv
// tb_burst_reader: directed bench for burst_reader. Keeps a copy of the
// buffer contents it has written and compares every beat, handshake gap,
// rd_last, done/busy and err against it.
module tb_burst_reader;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model [DEPTH];

  burst_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input int a, input logic [DW-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
    model[a]    = d;
  endtask

  // Presents a request for one edge; with keep set, start stays high.
  task automatic start_burst(input int a, input int len, input bit keep);
    bus.start      = 1'b1;
    bus.start_addr = AW'(a);
    bus.burst_len  = (AW+1)'(len);
    @(negedge clk);
    if (!keep) bus.start = 1'b0;
  endtask

  // Follows a running burst beat by beat. Optional stall of one beat and
  // optional write issued in the FETCH cycle of a chosen beat.
  task automatic expect_burst(input string tag, input int n, input int a0,
                              input int stall_beat, input int stall_cyc,
                              input int wbeat, input int waddr, input logic [DW-1:0] wdata);
    for (int i = 0; i < n; i++) begin
      int cnt;
      logic [DW-1:0] exp_d;
      exp_d = model[(a0 + i) % DEPTH];
      if (i == stall_beat) bus.rd_ready = 1'b0;
      if (i == wbeat) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(waddr);
        bus.wr_data = wdata;
      end
      cnt = 0;
      while (!bus.rd_valid && cnt < 8) begin
        @(negedge clk);
        bus.wr_en = 1'b0;
        cnt++;
      end
      check($sformatf("%s beat%0d gap", tag, i), cnt, 1);
      if (!bus.rd_valid) return;
      if (i == wbeat) model[waddr] = wdata;
      check($sformatf("%s beat%0d data", tag, i), bus.rd_data, exp_d);
      check($sformatf("%s beat%0d last", tag, i), bus.rd_last, (i == n - 1));
      check($sformatf("%s beat%0d busy", tag, i), bus.busy, 1);
      if (i == stall_beat) begin
        for (int s = 0; s < stall_cyc; s++) begin
          @(negedge clk);
          check($sformatf("%s stall%0d valid", tag, s), bus.rd_valid, 1);
          check($sformatf("%s stall%0d data", tag, s), bus.rd_data, exp_d);
        end
        bus.rd_ready = 1'b1;
      end
      @(negedge clk);
      check($sformatf("%s beat%0d valid drop", tag, i), bus.rd_valid, 0);
    end
    check({tag, " done"}, bus.done, 1);
    check({tag, " busy end"}, bus.busy, 0);
    bus.start = 1'b0;
    @(negedge clk);
    check({tag, " done pulse"}, bus.done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.burst_len  = '0;
    bus.rd_ready   = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst rd_valid", bus.rd_valid, 0);
    check("rst rd_last", bus.rd_last, 0);
    check("rst rd_data", bus.rd_data, 0);
    check("rst busy", bus.busy, 0);
    check("rst done", bus.done, 0);
    check("rst err", bus.err, 0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < DEPTH; i++) write_word(i, DW'(i + 16));

    // Basic burst 2..5 with consumer always ready
    start_burst(2, 4, 1'b0);
    check("T1 busy after start", bus.busy, 1);
    check("T1 valid after start", bus.rd_valid, 0);
    expect_burst("T1", 4, 2, -1, 0, -1, 0, 8'h00);

    // Same burst, beat 1 held off for 5 cycles
    start_burst(2, 4, 1'b0);
    expect_burst("T2", 4, 2, 1, 5, -1, 0, 8'h00);

    // Burst running past the last address
    start_burst(14, 4, 1'b0);
`ifdef BURST_READER_NOWRAP_EN
    check("T3 err pulse", bus.err, 1);
    check("T3 busy", bus.busy, 0);
    @(negedge clk);
    check("T3 err clear", bus.err, 0);
    for (int k = 0; k < 3; k++) begin
      check("T3 no valid", bus.rd_valid, 0);
      check("T3 no busy", bus.busy, 0);
      @(negedge clk);
    end
`else
    check("T3 err low", bus.err, 0);
    expect_burst("T3", 4, 14, -1, 0, -1, 0, 8'h00);
`endif

    // Full-depth burst
    start_burst(0, 16, 1'b0);
    expect_burst("T4", 16, 0, -1, 0, -1, 0, 8'h00);

    // Zero-length request is ignored
    start_burst(4, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("T5 busy", bus.busy, 0);
      check("T5 done", bus.done, 0);
      check("T5 valid", bus.rd_valid, 0);
      @(negedge clk);
    end

    // start held high with new parameters while busy
    start_burst(5, 2, 1'b1);
    bus.start_addr = 4'd9;
    bus.burst_len  = 5'd3;
    expect_burst("T6", 2, 5, -1, 0, -1, 0, 8'h00);
    check("T6 idle after", bus.busy, 0);

    // Write to address 3 in the cycle it is read: old data comes out
    start_burst(2, 4, 1'b0);
    expect_burst("T7", 4, 2, -1, 0, 1, 3, 8'hAA);
    check("T7 model", model[3], 8'hAA);
    start_burst(3, 2, 1'b0);
    expect_burst("T7b", 2, 3, -1, 0, -1, 0, 8'h00);

    // Reset asserted while a beat is held
    bus.rd_ready = 1'b0;
    start_burst(7, 1, 1'b0);
    @(negedge clk);
    check("T8 held valid", bus.rd_valid, 1);
    check("T8 held last", bus.rd_last, 1);
    check("T8 held data", bus.rd_data, 8'h17);
    #2 reset = 1'b0;
    #1;
    check("T8 rst valid", bus.rd_valid, 0);
    check("T8 rst busy", bus.busy, 0);
    check("T8 rst last", bus.rd_last, 0);
    check("T8 rst data", bus.rd_data, 0);
    @(negedge clk);
    reset = 1'b1;
    bus.rd_ready = 1'b1;
    @(negedge clk);
    start_burst(0, 4, 1'b0);
    expect_burst("T8", 4, 0, -1, 0, -1, 0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
